// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: cathode patterns,
// anode-off value, default digit count and the BCD-to-segment decoder.
`timescale 1ns/1ps
package seg_pkg;

  localparam int NUM_DIGITS_DEFAULT = 4;

  // Active-low cathode patterns ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // All anodes released (active-low)
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Non-BCD nibbles show a dash so bad data is visible rather than garbage.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for a slow asynchronous-ish level, with a
// programmable reset value and a one-cycle rising-edge pulse.
`timescale 1ns/1ps
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_reg;
  logic [STAGES-1:0] stage_in;
  logic              prev_reg;

  // Wire each stage to its predecessor; stage 0 takes the raw input.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_in[gi] = d;
      end else begin : g_rest
        assign stage_in[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  // Shift the sampled level down the chain; reset preloads the chosen level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= {STAGES{RESET_VAL}};
    end else begin
      sync_reg <= stage_in;
    end
  end

  // Remember the last synchronized level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg <= RESET_VAL;
    end else begin
      prev_reg <= level;
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = level & ~prev_reg;

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver. A synchronized scan clock
// steps through the digits; inputs are shadowed once per frame so a frame
// never mixes old and new values. Outputs are registered and only change
// in the cycle after a scan tick.
`timescale 1ns/1ps
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_DIGITS  = NUM_DIGITS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        segment_clk,
  input  logic        blinking_clk,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_en,
  input  logic        dp_en,
  input  logic        disp_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int              IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] DP_IDX   = IDX_W'(2);

  logic scan_tick;
  logic scan_level_unused;
  logic blink_phase;
  logic blink_rise_unused;

  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [15:0]      digits_sh_reg;
  logic [3:0]       blink_sh_reg;
  logic             dp_sh_reg;

  logic [3:0] an_reg, an_next;
  logic [6:0] seg_reg, seg_next;
  logic       dp_reg, dp_next;

  logic [3:0] nibble;
  logic       blank;

  // Scan clock: reset high so the divider's reset-high output gives no false tick.
  sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_scan_sync (
    .clk   (clk),
    .reset (reset),
    .d     (segment_clk),
    .level (scan_level_unused),
    .rise  (scan_tick)
  );

  // Blink clock: used as a level; reset high so digits show right after reset.
  sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_blink_sync (
    .clk   (clk),
    .reset (reset),
    .d     (blinking_clk),
    .level (blink_phase),
    .rise  (blink_rise_unused)
  );

  // Next digit index and frame-level shadow capture on the wrapping tick.
  always_comb begin
    idx_next = idx_reg;
    if (scan_tick) begin
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end
  end

  // Digit index and shadow registers; shadows reload only when the index wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg       <= '0;
      digits_sh_reg <= '0;
      blink_sh_reg  <= '0;
      dp_sh_reg     <= 1'b0;
    end else begin
      idx_reg <= idx_next;
      if (scan_tick && (idx_reg == IDX_LAST)) begin
        digits_sh_reg <= digits;
        blink_sh_reg  <= blink_en;
        dp_sh_reg     <= dp_en;
      end
    end
  end

  // Output pattern for the digit selected by the current index; hold otherwise.
  always_comb begin
    an_next  = an_reg;
    seg_next = seg_reg;
    dp_next  = dp_reg;
    nibble   = digits_sh_reg[{idx_reg, 2'b00} +: 4];
    blank    = blink_sh_reg[idx_reg] & ~blink_phase;
    if (scan_tick) begin
      if (!disp_en) begin
        an_next  = AN_OFF;
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
      end else begin
        an_next = ~(4'b0001 << idx_reg);
        if (blank) begin
          seg_next = SEG_BLANK;
          dp_next  = 1'b1;
        end else begin
          seg_next = seg_decode(nibble);
          dp_next  = ~((idx_reg == DP_IDX) & dp_sh_reg);
        end
      end
    end
  end

  // Registered display outputs; reset releases every anode and cathode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_reg  <= AN_OFF;
      seg_reg <= SEG_BLANK;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: a frame-level model predicts the
// display after each scan tick, a per-cycle compare checks the outputs,
// and literal expectations pin key patterns.
`timescale 1ns/1ps
module tb_seg_scan_driver;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        segment_clk;
  logic        blinking_clk;
  logic [15:0] digits;
  logic [3:0]  blink_en;
  logic        dp_en;
  logic        disp_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  always #5 clk = ~clk;

  seg_scan_driver #(.SYNC_STAGES(S), .NUM_DIGITS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .segment_clk  (segment_clk),
    .blinking_clk (blinking_clk),
    .digits       (digits),
    .blink_en     (blink_en),
    .dp_en        (dp_en),
    .disp_en      (disp_en),
    .an           (an),
    .seg          (seg),
    .dp           (dp)
  );

  int tests = 0;
  int fails = 0;
  int ntick = 0;

  logic       check_en = 1'b0;
  logic [3:0] exp_an   = 4'b1111;
  logic [6:0] exp_seg  = 7'b1111111;
  logic       exp_dp   = 1'b1;

  // Frame-level model state
  int         m_idx;
  logic [3:0] m_dig [4];
  logic       m_blink [4];
  logic       m_dp;
  logic [6:0] seg_tab [16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %b, need %b", name, $time, act, req);
    end
  endtask

  task automatic lit(input string name, input logic [3:0] a, input logic [6:0] s, input logic d);
    chk({name, "_an"}, {12'd0, an}, {12'd0, a});
    chk({name, "_seg"}, {9'd0, seg}, {9'd0, s});
    chk({name, "_dp"}, {15'd0, dp}, {15'd0, d});
  endtask

  task automatic model_reset();
    m_idx = 0;
    for (int i = 0; i < 4; i++) begin
      m_dig[i]   = 4'd0;
      m_blink[i] = 1'b0;
    end
    m_dp    = 1'b0;
    exp_an  = 4'b1111;
    exp_seg = 7'b1111111;
    exp_dp  = 1'b1;
  endtask

  // Every cycle the outputs must equal the model's current display.
  always @(negedge clk) begin
    if (check_en) begin
      chk("cycle", {4'd0, exp_dp, exp_an, exp_seg} ^ 16'd0 ^ {4'd0, dp, an, seg} ^ {4'd0, exp_dp, exp_an, exp_seg},
          {4'd0, exp_dp, exp_an, exp_seg});
    end
  end

  // One scan: low phase long enough to settle, then a rise; the new
  // display must appear exactly S+1 clock edges after the rise.
  task automatic tick();
    logic [3:0] n_an;
    logic [6:0] n_seg;
    logic       n_dp;
    logic       blank;
    @(negedge clk) segment_clk = 1'b0;
    repeat (S + 2) @(negedge clk);
    segment_clk = 1'b1;
    repeat (S) @(posedge clk);
    if (!disp_en) begin
      n_an  = 4'b1111;
      n_seg = 7'b1111111;
      n_dp  = 1'b1;
    end else begin
      n_an  = 4'b1111 ^ (4'b0001 << m_idx);
      blank = m_blink[m_idx] && !blinking_clk;
      n_seg = blank ? 7'b1111111 : seg_tab[m_dig[m_idx]];
      n_dp  = !(!blank && m_idx == 2 && m_dp);
    end
    if (m_idx == 3) begin
      for (int i = 0; i < 4; i++) begin
        m_dig[i]   = digits[4*i +: 4];
        m_blink[i] = blink_en[i];
      end
      m_dp = dp_en;
    end
    m_idx = (m_idx + 1) % 4;
    @(posedge clk);
    #1;
    exp_an  = n_an;
    exp_seg = n_seg;
    exp_dp  = n_dp;
    repeat (2) @(negedge clk);
    ntick++;
    $display("[TB] tick %0d: an=%b seg=%b dp=%b", ntick, an, seg, dp);
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;

    reset        = 1'b1;
    segment_clk  = 1'b1;
    blinking_clk = 1'b1;
    digits       = 16'h0000;
    blink_en     = 4'b0000;
    dp_en        = 1'b0;
    disp_en      = 1'b1;
    model_reset();
    #1 check_en = 1'b1;

    // Reset with segment_clk high, release, and hold: no update may occur.
    repeat (3) @(negedge clk);
    lit("rst", 4'b1111, 7'b1111111, 1'b1);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    lit("rst_hold", 4'b1111, 7'b1111111, 1'b1);

    // First frame shows reset shadow (zeros); wrap loads 1234.
    digits = 16'h1234;
    dp_en  = 1'b1;
    tick(); lit("first", 4'b1110, 7'b1000000, 1'b1);
    repeat (3) tick();

    // Scan order
    tick(); lit("scan0", 4'b1110, 7'b0011001, 1'b1);
    tick(); lit("scan1", 4'b1101, 7'b0110000, 1'b1);
    tick(); lit("scan2", 4'b1011, 7'b0100100, 1'b0);
    tick(); lit("scan3", 4'b0111, 7'b1111001, 1'b1);

    // Tearing: new digits arrive mid-frame
    tick(); tick();
    digits = 16'h5678;
    tick(); lit("tear2", 4'b1011, 7'b0100100, 1'b0);
    tick(); lit("tear3", 4'b0111, 7'b1111001, 1'b1);
    tick(); lit("new0", 4'b1110, 7'b0000000, 1'b1);
    tick();

    // Blink on digits 0 and 1
    blink_en     = 4'b0011;
    blinking_clk = 1'b0;
    tick(); tick();
    tick(); lit("blink0", 4'b1110, 7'b1111111, 1'b1);
    tick(); lit("blink1", 4'b1101, 7'b1111111, 1'b1);
    tick(); lit("blink2", 4'b1011, 7'b0000010, 1'b0);
    tick();
    blinking_clk = 1'b1;
    tick(); lit("unblink0", 4'b1110, 7'b0000000, 1'b1);
    tick(); lit("unblink1", 4'b1101, 7'b1111000, 1'b1);

    // Decode of non-BCD nibbles
    digits   = 16'hFEC9;
    blink_en = 4'b0000;
    dp_en    = 1'b0;
    tick(); tick();
    tick(); lit("dec9", 4'b1110, 7'b0010000, 1'b1);
    tick(); lit("decC", 4'b1101, 7'b0111111, 1'b1);
    tick(); lit("decE", 4'b1011, 7'b0111111, 1'b1);
    tick();

    // Display disable: index keeps rotating while blanked
    disp_en = 1'b0;
    tick(); lit("off0", 4'b1111, 7'b1111111, 1'b1);
    disp_en = 1'b1;
    tick(); lit("on1", 4'b1101, 7'b0111111, 1'b1);

    // Asynchronous reset at idx 2, between clock edges
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    lit("async_rst", 4'b1111, 7'b1111111, 1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    tick(); lit("post_rst", 4'b1110, 7'b1000000, 1'b1);
    tick(); lit("post_rst1", 4'b1101, 7'b1000000, 1'b1);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
